mp_issue_ctrl: RTL and testbench

Issue controller in front of mp_top. It shares the single 32-bit instruction port between N_REQ requesters using round-robin arbitration. It drops illegal opcodes and inserts bubble cycles (instruction = 0, opcode 0 = invalid) when a source register matches the destination of a recent in-flight instruction. Its registered `instruction` output drives mp_top.instruction directly.

---
 rtl/mp_issue_ctrl_pkg.sv | 57 +++++
 rtl/mp_rr_arbiter.sv | 71 +++++++
 rtl/mp_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mp_issue_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_issue_ctrl_pkg.sv
// Shared definitions for the mp_top issue controller: opcodes, instruction field
// positions, decode helpers and the issue FSM state type.
package mp_pkg;

  localparam logic [5:0] OP_MIN = 6'd1;
  localparam logic [5:0] OP_ADD = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_MAX = 6'd7;
  localparam logic [5:0] OP_AVG = 6'd9;
  localparam logic [5:0] OP_NOT = 6'd10;
  localparam logic [5:0] OP_AND = 6'd11;
  localparam logic [5:0] OP_INV = 6'd12;
  localparam logic [5:0] OP_ABS = 6'd13;
  localparam logic [5:0] OP_OR  = 6'd14;
  localparam logic [5:0] OP_SUB = 6'd15;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 6;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_LSB = 11;
  localparam int DST_LSB  = 16;
  localparam int REG_W    = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } issue_state_e;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [31:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [REG_W-1:0] get_src1(input logic [31:0] instr);
    return instr[SRC1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_src2(input logic [31:0] instr);
    return instr[SRC2_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_dst(input logic [31:0] instr);
    return instr[DST_LSB +: REG_W];
  endfunction

  function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
    case (op)
      OP_MIN, OP_ADD, OP_XOR, OP_MAX, OP_AVG, OP_NOT,
      OP_AND, OP_INV, OP_ABS, OP_OR, OP_SUB: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [OPC_W-1:0] op);
    return (op == OP_NOT) || (op == OP_INV) || (op == OP_ABS);
  endfunction

endpackage

// File: rtl/mp_rr_arbiter.sv
// Requester arbiter: round-robin from a registered pointer, or fixed priority
// (requester 0 highest, no pointer) when MP_ISSUE_PRIO_EN is defined.
module mp_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [IDX_W-1:0] adv_idx,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

`ifdef MP_ISSUE_PRIO_EN
  logic unused_prio;
  assign unused_prio = ^{clk, reset, advance, adv_idx};

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // First pass covers pointer..top, second pass wraps to the bottom.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!grant_vld && req[j] && (j >= int'(ptr_q))) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        grant_vld = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!grant_vld && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(adv_idx) == N_REQ - 1) ? '0 : adv_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/mp_issue_ctrl.sv
// Issue controller for mp_top: arbitrates requesters, drops illegal ops and inserts
// hazard bubbles. Define MP_ISSUE_PRIO_EN for fixed priority instead of round-robin.
module mp_issue_ctrl
  import mp_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int HAZARD_DEPTH = 2,
  parameter int STALL_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_instr,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          instruction,
  output logic                 issue_valid,
  output logic [2:0]           issue_id,
  output logic                 err_opcode,
  output logic [STALL_W-1:0]   stall_cnt
);

  localparam int IDX_W = 3;

  issue_state_e                        state_q, state_d;
  logic [IDX_W-1:0]                    lock_q, lock_d;
  logic [HAZARD_DEPTH-1:0]             sb_vld_q, sb_vld_d;
  logic [HAZARD_DEPTH-1:0][REG_W-1:0]  sb_dst_q, sb_dst_d;
  logic [31:0]                         instr_q, instr_d;
  logic                                issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]                    issue_id_q, issue_id_d;
  logic                                err_q, err_d;
  logic [STALL_W-1:0]                  stall_q, stall_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic [IDX_W-1:0] cand_idx;
  logic             cand_req;
  logic [31:0]      cand_instr;
  logic             hazard, accept, issue, drop, stall;

  mp_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (accept),
    .adv_idx   (cand_idx),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // While holding, the locked requester is the only candidate.
  always_comb begin
    cand_idx   = (state_q == ST_HOLD) ? lock_q : arb_idx;
    cand_req   = 1'b0;
    cand_instr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (int'(cand_idx) == k) begin
        cand_req   = req_valid[k];
        cand_instr = req_instr[32*k +: 32];
      end
    end
    hazard = 1'b0;
    for (int e = 0; e < HAZARD_DEPTH; e++) begin
      if (sb_vld_q[e] && ((sb_dst_q[e] == get_src1(cand_instr)) ||
          (!is_unary(get_opcode(cand_instr)) && (sb_dst_q[e] == get_src2(cand_instr))))) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    req_ready = '0;
    accept    = 1'b0;
    issue     = 1'b0;
    drop      = 1'b0;
    stall     = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            if (!is_legal_opcode(get_opcode(cand_instr))) begin
              accept = 1'b1;
              drop   = 1'b1;
            end else if (!hazard) begin
              accept = 1'b1;
              issue  = 1'b1;
            end else begin
              stall   = 1'b1;
              lock_d  = arb_idx;
              state_d = ST_HOLD;
            end
            if (accept) req_ready = arb_grant;
          end
        end
        ST_HOLD: begin
          if (!cand_req) begin
            state_d = ST_IDLE;
          end else if (hazard) begin
            stall = 1'b1;
          end else begin
            accept  = 1'b1;
            issue   = 1'b1;
            state_d = ST_IDLE;
            for (int k = 0; k < N_REQ; k++) req_ready[k] = (int'(lock_q) == k);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    instr_d       = issue ? cand_instr : '0;
    issue_valid_d = issue;
    issue_id_d    = issue ? cand_idx : '0;
    err_d         = drop;
    stall_d       = stall_q;
    if (stall && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
    sb_vld_d[0] = issue;
    sb_dst_d[0] = issue ? get_dst(cand_instr) : '0;
    for (int e = 1; e < HAZARD_DEPTH; e++) begin
      sb_vld_d[e] = sb_vld_q[e-1];
      sb_dst_d[e] = sb_dst_q[e-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lock_q        <= '0;
      sb_vld_q      <= '0;
      instr_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      err_q         <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      lock_q        <= lock_d;
      sb_vld_q      <= sb_vld_d;
      instr_q       <= instr_d;
      issue_valid_q <= issue_valid_d;
      issue_id_q    <= issue_id_d;
      err_q         <= err_d;
      stall_q       <= stall_d;
    end
    sb_dst_q <= sb_dst_d;
  end

  assign instruction = instr_q;
  assign issue_valid = issue_valid_q;
  assign issue_id    = issue_id_q;
  assign err_opcode  = err_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_mp_issue_ctrl.sv
// Directed bench for mp_issue_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_mp_issue_ctrl;

  localparam int N_REQ   = 2;
  localparam int HD      = 2;
  localparam int STALL_W = 16;
`ifdef MP_ISSUE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  localparam logic [31:0] ADD   = 32'h00051043; // ADD r1,r2 -> r5
  localparam logic [31:0] SUB   = 32'h0006194F; // SUB r5,r3 -> r6
  localparam logic [31:0] OPA   = 32'h00071043; // ADD r1,r2 -> r7
  localparam logic [31:0] OPB   = 32'h000820C5; // XOR r3,r4 -> r8
  localparam logic [31:0] NOT_H = 32'h0007294A; // NOT src1=r5
  localparam logic [31:0] NOT_C = 32'h0007284A; // NOT src1=r1, src2=r5 ignored

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req_valid;
  logic [32*N_REQ-1:0]  req_instr;
  logic [N_REQ-1:0]     req_ready;
  logic [31:0]          instruction;
  logic                 issue_valid;
  logic [2:0]           issue_id;
  logic                 err_opcode;
  logic [STALL_W-1:0]   stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  int               m_hist[HD];
  int               m_ptr, m_lock, m_stall;
  logic [N_REQ-1:0] e_ready, last_ready;
  logic [31:0]      e_instr;
  logic             e_vld, e_err;
  int               e_id;

  mp_issue_ctrl #(.N_REQ(N_REQ), .HAZARD_DEPTH(HD), .STALL_W(STALL_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_ready   (req_ready),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .issue_id    (issue_id),
    .err_opcode  (err_opcode),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] ins);
    req_valid[i]          = v;
    req_instr[32*i +: 32] = ins;
  endtask

  // Spec-level model: pick a requester, classify it, update history of issued dsts.
  task automatic model_step();
    int w, nd, op, s1, s2, d;
    logic [31:0] ins;
    bit legal, unary, haz, stl;
    e_ready = '0; e_instr = '0; e_vld = 1'b0; e_id = 0; e_err = 1'b0;
    if (reset) begin
      foreach (m_hist[e]) m_hist[e] = -1;
      m_ptr = 0; m_lock = -1; m_stall = 0;
      return;
    end
    w = -1; nd = -1; stl = 1'b0;
    if (m_lock >= 0) begin
      if (req_valid[m_lock] === 1'b1) w = m_lock;
      else m_lock = -1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        int c;
        c = PRIO ? k : (m_ptr + k) % N_REQ;
        if (w < 0 && req_valid[c] === 1'b1) w = c;
      end
    end
    if (w >= 0) begin
      ins   = req_instr[32*w +: 32];
      op    = int'(ins % 64);
      s1    = int'((ins / 64) % 32);
      s2    = int'((ins / 2048) % 32);
      d     = int'((ins / 65536) % 32);
      legal = op inside {1, 3, 5, 7, 9, 10, 11, 12, 13, 14, 15};
      unary = op inside {10, 12, 13};
      haz   = 1'b0;
      foreach (m_hist[e])
        if (m_hist[e] >= 0 && (m_hist[e] == s1 || (!unary && m_hist[e] == s2))) haz = 1'b1;
      if (!legal) begin
        e_ready[w] = 1'b1; e_err = 1'b1; m_ptr = (w + 1) % N_REQ;
      end else if (haz) begin
        m_lock = w; stl = 1'b1;
      end else begin
        e_ready[w] = 1'b1; e_instr = ins; e_vld = 1'b1; e_id = w; nd = d;
        m_lock = -1; m_ptr = (w + 1) % N_REQ;
      end
    end
    for (int e = HD - 1; e > 0; e--) m_hist[e] = m_hist[e-1];
    m_hist[0] = nd;
    if (stl && m_stall < (2**STALL_W) - 1) m_stall++;
  endtask

  // One clock: check the combinational handshake before the edge, registered outputs after.
  task automatic tick();
    #1;
    model_step();
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    last_ready = req_ready;
    @(posedge clk);
    #1;
    chk("instruction", instruction, e_instr);
    chk("issue_valid", 32'(issue_valid), 32'(e_vld));
    if (e_vld) chk("issue_id", 32'(issue_id), e_id);
    chk("err_opcode", 32'(err_opcode), 32'(e_err));
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_instr = '0;
    tick(); tick();
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_valid", 32'(issue_valid), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    reset = 1'b0;
    tick(); tick();

    set_req(0, 1'b1, ADD); tick(); set_req(0, 1'b0, '0);
    chk("single_instr", instruction, ADD);
    chk("single_valid", 32'(issue_valid), 32'h1);
    chk("single_id", 32'(issue_id), 32'h0);
    chk("single_stall", 32'(stall_cnt), 32'h0);
    tick(); tick();

    set_req(0, 1'b1, ADD); tick(); set_req(0, 1'b1, SUB);
    tick(); chk("raw_bubble1", instruction, 32'h0);
    tick(); chk("raw_bubble2", instruction, 32'h0);
    tick(); chk("raw_issue", instruction, SUB);
    chk("raw_stall", 32'(stall_cnt), 32'd2);
    set_req(0, 1'b0, '0); tick(); tick();

    set_req(1, 1'b1, 32'h00000002); tick();
    chk("ill_ready", 32'(last_ready), 32'h2);
    chk("ill_err", 32'(err_opcode), 32'h1);
    chk("ill_valid", 32'(issue_valid), 32'h0);
    set_req(1, 1'b0, '0); tick();
    chk("ill_err_clear", 32'(err_opcode), 32'h0);

    set_req(0, 1'b1, OPA); set_req(1, 1'b1, OPB);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_id", 32'(issue_id), PRIO ? 0 : k % 2);
    end
    set_req(0, 1'b0, '0); set_req(1, 1'b0, '0); tick(); tick();

    set_req(1, 1'b1, ADD); tick();
    set_req(1, 1'b1, OPB); set_req(0, 1'b1, SUB);
    tick(); chk("hold_ready", 32'(last_ready), 32'h0);
    tick(); chk("hold_frozen", 32'(last_ready), 32'h0);
    tick(); chk("hold_issue", instruction, SUB);
    chk("hold_issue_id", 32'(issue_id), 32'h0);
    set_req(0, 1'b0, '0); tick();
    chk("after_hold_id", 32'(issue_id), 32'h1);
    set_req(1, 1'b0, '0); tick(); tick();

    set_req(0, 1'b1, ADD); tick(); set_req(0, 1'b1, SUB); tick();
    reset = 1'b1; tick();
    chk("rst_hold_instr", instruction, 32'h0);
    chk("rst_hold_stall", 32'(stall_cnt), 32'h0);
    chk("rst_hold_ready", 32'(last_ready), 32'h0);
    reset = 1'b0; tick();
    chk("post_rst_issue", instruction, SUB);
    set_req(0, 1'b0, '0); tick(); tick();

    set_req(0, 1'b1, ADD); tick(); set_req(0, 1'b1, SUB); tick();
    set_req(0, 1'b0, '0); tick();
    chk("drop_lock_valid", 32'(issue_valid), 32'h0);
    set_req(1, 1'b1, OPB); tick();
    chk("drop_lock_next", 32'(issue_id), 32'h1);
    set_req(1, 1'b0, '0); tick(); tick();

    set_req(0, 1'b1, ADD); tick(); set_req(0, 1'b1, NOT_H);
    tick(); chk("unary_stall", instruction, 32'h0);
    tick(); tick(); chk("unary_late_issue", instruction, NOT_H);
    set_req(0, 1'b0, '0); tick(); tick();
    set_req(0, 1'b1, ADD); tick(); set_req(0, 1'b1, NOT_C);
    tick(); chk("unary_src2_ignored", instruction, NOT_C);
    set_req(0, 1'b0, '0); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
